hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Sequencing controller for the shared multicycle arithmetic resources, the divider and the multiplier, in the MIPS datapath. It accepts MULT/DIV/MTHI/MTLO/MFHI/MFLO requests from the decode/execute stage and launches the selected engine with a one-cycle start pulse. It then waits on the engine's done or div-by-zero signal, commits results to the architectural HI/LO registers and stalls the pipeline while a result is outstanding.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- TIMEOUT, 64, max cycles waiting for engine completion before abort

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- op_valid  in  1  request present this cycle
- op_code  in  3  000 NONE, 001 DIV, 010 MULT, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO, 111 reserved (treated as NONE)
- op_a, op_b  in  WIDTH  operands (op_a = rs: dividend/multiplicand/MT data; op_b = rt)
- stall  out  1  hold the issuing stage
- busy  out  1  engine operation outstanding
- rd_data  out  WIDTH  MFHI/MFLO result
- hi, lo  out  WIDTH  architectural HI/LO
- div_start, mult_start  out  1  one-cycle launch pulses
- eng_a, eng_b  out  WIDTH  registered engine operands
- div_done, div_zero, mult_done  in  1  engine completion flags
- div_hi, div_lo, mult_hi, mult_lo  in  WIDTH  engine results
- dz_err, to_err  out  1  one-cycle pulses: divide-by-zero, timeout

## Operation
- FSM states: IDLE, DIV_RUN, MULT_RUN.
- A request is accepted only when `op_valid` is high in IDLE with a non-NONE code.
- DIV/MULT accept: latch `op_a`/`op_b` into `eng_a`/`eng_b`, clear the timeout counter, move to the RUN state, and assert the matching start for exactly the next cycle.
- RUN states ignore completion inputs during the start-pulse cycle and sample them from the following cycle.
- DIV_RUN:
  - `div_zero` high: HI/LO unchanged, pulse `dz_err`, go to IDLE. `div_zero` wins over a simultaneous `div_done`.
  - Otherwise `div_done` high: HI ← `div_hi`, LO ← `div_lo`, go to IDLE.
- MULT_RUN: `mult_done` high: HI ← `mult_hi`, LO ← `mult_lo`, go to IDLE.
- Timeout: the counter increments each RUN cycle. When it reaches TIMEOUT with no completion, pulse `to_err`, HI/LO unchanged, go to IDLE.
- MTHI/MTLO in IDLE: HI/LO ← `op_a` at the accepting edge. No stall.
- MFHI/MFLO in IDLE: `rd_data` = current `hi`/`lo`, combinational, no stall. `rd_data` = 0 for any other op.
- `stall` = `op_valid` && code≠NONE && state≠IDLE. Stalled requests are not accepted; they are retried by the holding stage.
- `busy` = state≠IDLE.
- Completion inputs received in IDLE are ignored.

## Timing
- Reset (async, `reset`=0): state IDLE; `hi`, `lo`, `eng_a`, `eng_b`, counter = 0; `div_start`, `mult_start`, `dz_err`, `to_err` = 0; `busy` = 0.
- Reset mid-RUN aborts immediately. Stale completion after reset release is ignored.
- DIV/MULT accepted in cycle T: start high in T+1.
- Completion seen in cycle T+k (k≥2): HI/LO updated at the end of T+k, `busy` low in T+k+1, a stalled MFHI/MFLO is accepted and returns the new value in T+k+1.
- Minimum occupancy is 2 cycles.
- MTHI at edge E is visible to MFHI in the next cycle.
- `dz_err`/`to_err` are registered and high for exactly the cycle after detection.

## Structure
- Package `hilo_pkg`: `op_code` encodings, FSM state encoding, WIDTH default.
- Sub-module `hilo_timeout_cnt`: clear/enable counter with `expired` flag, width $clog2(TIMEOUT+1).
- HI/LO registers, operand latches and FSM stay in `hilo_ctrl`.

## Test plan
- DIV `op_a`=7, `op_b`=-2; engine model returns hi=1, lo=0xFFFFFFFD after 33 cycles -> `div_start` pulses once in T+1, `busy` stays high until completion, then `hi`=1, `lo`=0xFFFFFFFD, no errors.
- MFLO issued the cycle after DIV accept -> `stall`=1 every cycle until completion; in the next cycle `rd_data`=new LO and `stall`=0.
- DIV with `op_b`=0; engine raises `div_zero` at T+3 -> `dz_err` pulse at T+4, HI/LO keep prior values (0x11/0x22), state IDLE.
- MULT where the engine never completes -> `to_err` pulse after TIMEOUT=64 RUN cycles, `busy` falls, HI/LO unchanged. A subsequent MULT is accepted normally.
- `reset`=0 asserted in mid-DIV_RUN, then `div_done` applied after release -> all outputs 0 immediately, the late `div_done` is ignored, `hi`=`lo`=0.
- MTHI 0x00001234 then MFHI the next cycle -> `rd_data`=0x00001234, `stall` never asserted. Simultaneous `div_done` in IDLE has no effect.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencing controller: opcode and
// FSM state encodings plus default sizing.
package hilo_pkg;

  localparam int HILO_WIDTH   = 32;
  localparam int HILO_TIMEOUT = 64;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_DIV  = 3'b001,
    OP_MULT = 3'b010,
    OP_MTHI = 3'b011,
    OP_MTLO = 3'b100,
    OP_MFHI = 3'b101,
    OP_MFLO = 3'b110,
    OP_RSVD = 3'b111
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DIV_RUN  = 2'b01,
    ST_MULT_RUN = 2'b10
  } hilo_state_e;

  // The reserved code behaves exactly like NONE.
  function automatic logic is_active_op(input logic [2:0] code);
    return (code != OP_NONE) && (code != OP_RSVD);
  endfunction

endpackage

// File: rtl/hilo_timeout_cnt.sv
// Engine watchdog: counts cycles spent waiting on an engine and flags the
// cycle in which the count reaches TIMEOUT, so the abort edge lands after
// exactly TIMEOUT waiting cycles.
module hilo_timeout_cnt #(
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LP_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Cycle counter: cleared on launch, saturates at TIMEOUT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // This cycle's increment brings the count to TIMEOUT
  assign o_expired = i_en && (r_cnt >= LP_LAST);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencing controller: launches the divider or multiplier with a
// one-cycle start pulse, waits for completion, commits HI/LO and stalls
// the issuing stage while an engine result is outstanding.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH   = HILO_WIDTH,
  parameter int TIMEOUT = HILO_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_start,
  output logic             mult_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             div_done,
  input  logic             div_zero,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic             dz_err,
  output logic             to_err
);

  hilo_state_e      r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_eng_a;
  logic [WIDTH-1:0] r_eng_b;
  logic             r_div_start;
  logic             r_mult_start;
  logic             r_dz_err;
  logic             r_to_err;

  logic             w_idle;
  logic             w_launch;
  logic             w_expired;
  logic [WIDTH-1:0] w_rd_data;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_launch = w_idle && op_valid &&
                    ((op_code == OP_DIV) || (op_code == OP_MULT));

  hilo_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clr     (w_launch),
    .i_en      (!w_idle),
    .o_expired (w_expired)
  );

  // Sequencing FSM with HI/LO, operand latches and registered pulse outputs.
  // The start-pulse cycle doubles as the "ignore completion" marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_hi         <= {WIDTH{1'b0}};
      r_lo         <= {WIDTH{1'b0}};
      r_eng_a      <= {WIDTH{1'b0}};
      r_eng_b      <= {WIDTH{1'b0}};
      r_div_start  <= 1'b0;
      r_mult_start <= 1'b0;
      r_dz_err     <= 1'b0;
      r_to_err     <= 1'b0;
    end else begin
      r_div_start  <= 1'b0;
      r_mult_start <= 1'b0;
      r_dz_err     <= 1'b0;
      r_to_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            case (hilo_op_e'(op_code))
              OP_DIV: begin
                r_eng_a     <= op_a;
                r_eng_b     <= op_b;
                r_div_start <= 1'b1;
                r_state     <= ST_DIV_RUN;
              end
              OP_MULT: begin
                r_eng_a      <= op_a;
                r_eng_b      <= op_b;
                r_mult_start <= 1'b1;
                r_state      <= ST_MULT_RUN;
              end
              OP_MTHI: r_hi <= op_a;
              OP_MTLO: r_lo <= op_a;
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_DIV_RUN: begin
          if (!r_div_start) begin
            if (div_zero) begin
              r_dz_err <= 1'b1;
              r_state  <= ST_IDLE;
            end else if (div_done) begin
              r_hi    <= div_hi;
              r_lo    <= div_lo;
              r_state <= ST_IDLE;
            end else if (w_expired) begin
              r_to_err <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end
        end
        ST_MULT_RUN: begin
          if (!r_mult_start) begin
            if (mult_done) begin
              r_hi    <= mult_hi;
              r_lo    <= mult_lo;
              r_state <= ST_IDLE;
            end else if (w_expired) begin
              r_to_err <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MFHI/MFLO read port: only an idle controller returns HI/LO
  always_comb begin
    w_rd_data = {WIDTH{1'b0}};
    if (w_idle && op_valid && (op_code == OP_MFHI)) begin
      w_rd_data = r_hi;
    end else if (w_idle && op_valid && (op_code == OP_MFLO)) begin
      w_rd_data = r_lo;
    end else begin
      w_rd_data = {WIDTH{1'b0}};
    end
  end

  assign busy       = !w_idle;
  assign stall      = op_valid && is_active_op(op_code) && !w_idle;
  assign rd_data    = w_rd_data;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign eng_a      = r_eng_a;
  assign eng_b      = r_eng_b;
  assign div_start  = r_div_start;
  assign mult_start = r_mult_start;
  assign dz_err     = r_dz_err;
  assign to_err     = r_to_err;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: a cycle-accurate engine model drives
// completions, expected HI/LO pairs are queued at issue and popped when the
// controller returns to idle.
module tb_hilo_ctrl;

  localparam int TIMEOUT = 64;
  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_DIV  = 3'b001;
  localparam logic [2:0] C_MULT = 3'b010;
  localparam logic [2:0] C_MTHI = 3'b011;
  localparam logic [2:0] C_MTLO = 3'b100;
  localparam logic [2:0] C_MFHI = 3'b101;
  localparam logic [2:0] C_MFLO = 3'b110;
  localparam logic [2:0] C_RSVD = 3'b111;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        stall, busy;
  logic [31:0] rd_data, hi, lo, eng_a, eng_b;
  logic        div_start, mult_start;
  logic        div_done, div_zero, mult_done;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
  logic        dz_err, to_err;

  int          n_chk;
  int          n_fail;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  hilo_ctrl #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .rd_data(rd_data),
    .hi(hi), .lo(lo), .div_start(div_start), .mult_start(mult_start),
    .eng_a(eng_a), .eng_b(eng_b), .div_done(div_done), .div_zero(div_zero),
    .mult_done(mult_done), .div_hi(div_hi), .div_lo(div_lo),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .dz_err(dz_err), .to_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_engine();
    div_done = 1'b0; div_zero = 1'b0; mult_done = 1'b0;
    div_hi = 32'h0; div_lo = 32'h0; mult_hi = 32'h0; mult_lo = 32'h0;
  endtask

  // Issue DIV/MULT, run the engine model, check every cycle until idle.
  // k = completion cycle after accept (0 = never completes).
  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int k, input bit zero_kind, input bit glitch,
                        input logic [2:0] follow, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit exp_dz, input bit exp_to);
    int exit_c;
    logic [63:0] exp_pair;
    logic signed [63:0] sa, sbv, prod;
    exit_c = (k != 0) ? k + 1 : TIMEOUT + 1;
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    sb_q.push_back({exp_hi, exp_lo});
    #1;
    check("accept_stall", stall, 1'b0);
    for (int c = 1; c <= exit_c; c++) begin
      next_cycle();
      op_valid = (follow != C_NONE); op_code = follow; op_a = 32'h0; op_b = 32'h0;
      clear_engine();
      if ((c == k) || (glitch && (c == 1))) begin
        if (code == C_DIV) begin
          div_done = 1'b1;
          div_zero = zero_kind && (c == k);
          if (zero_kind || (c != k)) begin
            div_hi = 32'hDEAD0001; div_lo = 32'hDEAD0002;
          end else begin
            div_hi = $signed(eng_a) % $signed(eng_b);
            div_lo = $signed(eng_a) / $signed(eng_b);
          end
        end else begin
          mult_done = 1'b1;
          sa = $signed(eng_a); sbv = $signed(eng_b); prod = sa * sbv;
          if (c != k) prod = 64'hBAD0BAD0BAD0BAD0;
          mult_hi = prod[63:32]; mult_lo = prod[31:0];
        end
      end
      #1;
      check("busy", busy, c < exit_c);
      check("stall", stall, (follow != C_NONE) && (c < exit_c));
      check("div_start", div_start, (c == 1) && (code == C_DIV));
      check("mult_start", mult_start, (c == 1) && (code == C_MULT));
      check("dz_err", dz_err, exp_dz && (c == exit_c));
      check("to_err", to_err, exp_to && (c == exit_c));
      if (c == 1) begin
        check("eng_a", eng_a, a);
        check("eng_b", eng_b, b);
      end
      if ((c < exit_c) && (follow != C_NONE)) check("rd_data_held", rd_data, 32'h0);
      if (c == exit_c) begin
        exp_pair = sb_q.pop_front();
        check("hi", hi, exp_pair[63:32]);
        check("lo", lo, exp_pair[31:0]);
        if (follow == C_MFHI) check("rd_data_hi", rd_data, exp_pair[63:32]);
        if (follow == C_MFLO) check("rd_data_lo", rd_data, exp_pair[31:0]);
      end
    end
    next_cycle();
    op_valid = 1'b0; op_code = C_NONE; clear_engine();
    #1;
    check("dz_err_end", dz_err, 1'b0);
    check("to_err_end", to_err, 1'b0);
    check("busy_end", busy, 1'b0);
    m_hi = exp_hi; m_lo = exp_lo;
  endtask

  task automatic mt(input logic [2:0] code, input logic [31:0] v);
    op_valid = 1'b1; op_code = code; op_a = v;
    #1;
    check("mt_stall", stall, 1'b0);
    next_cycle();
    op_valid = 1'b0; op_code = C_NONE; op_a = 32'h0;
    #1;
    if (code == C_MTHI) begin
      m_hi = v; check("mthi", hi, v);
    end else begin
      m_lo = v; check("mtlo", lo, v);
    end
  endtask

  // MFHI/MFLO in idle, optionally with stray completions that must be ignored
  task automatic mf(input logic [2:0] code, input bit stray_done);
    logic [63:0] exp_v;
    op_valid = 1'b1; op_code = code;
    sb_q.push_back({32'h0, (code == C_MFHI) ? m_hi : m_lo});
    if (stray_done) begin
      div_done = 1'b1; div_hi = 32'hFFFF0000; div_lo = 32'h0000FFFF;
      mult_done = 1'b1; mult_hi = 32'hABCD0000; mult_lo = 32'h0000ABCD;
    end
    #1;
    exp_v = sb_q.pop_front();
    check("mf_rd_data", rd_data, exp_v[31:0]);
    check("mf_stall", stall, 1'b0);
    next_cycle();
    op_valid = 1'b0; op_code = C_NONE; clear_engine();
    #1;
    check("mf_hi_kept", hi, m_hi);
    check("mf_lo_kept", lo, m_lo);
    check("mf_busy", busy, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_hi = 32'h0; m_lo = 32'h0;
    reset = 1'b0; op_valid = 1'b0; op_code = C_NONE; op_a = 32'h0; op_b = 32'h0;
    clear_engine();
    repeat (2) next_cycle();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_eng_a", eng_a, 32'h0);
    check("rst_starts", {div_start, mult_start}, 2'b00);
    check("rst_errs", {dz_err, to_err}, 2'b00);
    reset = 1'b1;
    next_cycle();

    // DIV 7 / -2, completion at T+33, MFLO waiting from T+1
    run_op(C_DIV, 32'd7, 32'hFFFFFFFE, 33, 1'b0, 1'b0, C_MFLO,
           32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);

    // MTHI then MFHI with stray completions in idle
    mt(C_MTHI, 32'h00001234);
    mf(C_MFHI, 1'b1);
    mt(C_MTHI, 32'h00000011);
    mt(C_MTLO, 32'h00000022);
    mf(C_MFLO, 1'b0);

    // Divide by zero raised at T+3, together with div_done
    run_op(C_DIV, 32'd5, 32'd0, 3, 1'b1, 1'b0, C_NONE,
           32'h00000011, 32'h00000022, 1'b1, 1'b0);

    // MULT that never completes: timeout after TIMEOUT run cycles
    run_op(C_MULT, 32'd9, 32'd9, 0, 1'b0, 1'b0, C_MFHI,
           32'h00000011, 32'h00000022, 1'b0, 1'b1);

    // MULT 3 * -5 with a spurious done during the start cycle
    run_op(C_MULT, 32'd3, 32'hFFFFFFFB, 4, 1'b0, 1'b1, C_NONE,
           32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);

    // Minimum occupancy MULT 2^16 * 2^16, MFHI waiting
    run_op(C_MULT, 32'h00010000, 32'h00010000, 2, 1'b0, 1'b0, C_MFHI,
           32'h00000001, 32'h00000000, 1'b0, 1'b0);

    // Reset in the middle of a DIV
    op_valid = 1'b1; op_code = C_DIV; op_a = 32'd100; op_b = 32'd7;
    next_cycle();
    op_valid = 1'b0; op_code = C_NONE;
    repeat (5) next_cycle();
    check("mid_busy", busy, 1'b1);
    op_valid = 1'b1; op_code = C_RSVD;
    #1;
    check("rsvd_stall", stall, 1'b0);
    op_code = C_NONE;
    #1;
    check("none_stall", stall, 1'b0);
    op_code = C_MFHI;
    #1;
    check("mf_run_stall", stall, 1'b1);
    op_valid = 1'b0; op_code = C_NONE;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_hilo", {hi, lo}, 64'h0);
    check("arst_eng", {eng_a, eng_b}, 64'h0);
    check("arst_pulses", {div_start, mult_start, dz_err, to_err}, 4'b0000);
    next_cycle();
    reset = 1'b1;
    div_done = 1'b1; div_hi = 32'h00000055; div_lo = 32'h00000066;
    next_cycle();
    clear_engine();
    #1;
    check("late_done_hilo", {hi, lo}, 64'h0);
    check("late_done_busy", busy, 1'b0);
    m_hi = 32'h0; m_lo = 32'h0;

    // Normal operation after reset
    run_op(C_MULT, 32'd6, 32'd7, 5, 1'b0, 1'b0, C_MFLO,
           32'h00000000, 32'h0000002A, 1'b0, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
